// File: rtl/uart_cmd_framer.sv
// Assembles 7-byte plotter command frames from uart_rx byte strobes and
// presents validated commands over a valid/ready slot, counting rejected frames.
//
// state | meaning
// HUNT  | waiting for SYNC_BYTE, all other bytes discarded
// BODY  | collecting OP, XH, XL, YH, YL into the frame buffer
// CHECK | next strobe is the checksum byte; frame is judged on it
module uart_cmd_framer #(
  parameter int         TIMEOUT_CLKS = 52090,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Cmd_Valid,
  input  logic        i_Cmd_Ready,
  output logic [2:0]  o_Cmd_Op,
  output logic [15:0] o_Cmd_X,
  output logic [15:0] o_Cmd_Y,
  output logic        o_Frame_Err,
  output logic [7:0]  o_Err_Count
);

  localparam int            IW       = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    BODY  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      acc_q, acc_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [4:0][7:0] body_q, body_d;

  logic frame_done;
  logic timeout_hit;
  logic release_slot;
  logic op_ok;
  logic frame_good;
  logic err_now;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= HUNT;
      idx_q   <= '0;
      acc_q   <= '0;
      idle_q  <= '0;
      body_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      idle_q  <= idle_d;
      body_q  <= body_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    idle_d      = idle_q;
    body_d      = body_q;
    frame_done  = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      HUNT: begin
        idle_d = '0;
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
          state_d = BODY;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      BODY: begin
        if (i_Rx_DV) begin
          body_d[idx_q] = i_Rx_Byte;
          acc_d         = acc_q ^ i_Rx_Byte;
          idle_d        = '0;
          if (idx_q == 3'd4) begin
            state_d = CHECK;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else if (idle_q == IDLE_MAX) begin
          timeout_hit = 1'b1;
          state_d     = HUNT;
          idle_d      = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      CHECK: begin
        // A strobe on the limit cycle takes priority over the timeout.
        if (i_Rx_DV) begin
          frame_done = 1'b1;
          state_d    = HUNT;
          idle_d     = '0;
        end else if (idle_q == IDLE_MAX) begin
          timeout_hit = 1'b1;
          state_d     = HUNT;
          idle_d      = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: begin
        state_d = HUNT;
        idx_d   = '0;
        acc_d   = '0;
        idle_d  = '0;
      end
    endcase
  end

  assign release_slot = o_Cmd_Valid & i_Cmd_Ready;
  assign op_ok        = (body_q[0][7:3] == 5'd0) && (body_q[0][2:0] != 3'd0) &&
                        (body_q[0][2:0] <= 3'd5);
  // A held command is never overwritten; a same-cycle release frees the slot.
  assign frame_good   = frame_done && (i_Rx_Byte == acc_q) && op_ok &&
                        (!o_Cmd_Valid || release_slot);
  assign err_now      = (frame_done && !frame_good) || timeout_hit;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Cmd_Valid <= 1'b0;
      o_Cmd_Op    <= '0;
      o_Cmd_X     <= '0;
      o_Cmd_Y     <= '0;
      o_Frame_Err <= 1'b0;
      o_Err_Count <= '0;
    end else begin
      if (frame_good) begin
        o_Cmd_Valid <= 1'b1;
        o_Cmd_Op    <= body_q[0][2:0];
        o_Cmd_X     <= {body_q[1], body_q[2]};
        o_Cmd_Y     <= {body_q[3], body_q[4]};
      end else if (release_slot) begin
        o_Cmd_Valid <= 1'b0;
      end
      o_Frame_Err <= err_now;
      if (err_now && (o_Err_Count != 8'hFF)) begin
        o_Err_Count <= o_Err_Count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Bench for uart_cmd_framer: directed scenarios plus randomized frame traffic
// checked against a queue-based frame model.
module tb_uart_cmd_framer;

  localparam int         T    = 20;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        i_Clock = 1'b0;
  logic        i_Reset = 1'b0;
  logic        i_Rx_DV = 1'b0;
  logic [7:0]  i_Rx_Byte = 8'h00;
  logic        i_Cmd_Ready = 1'b0;
  logic        o_Cmd_Valid;
  logic [2:0]  o_Cmd_Op;
  logic [15:0] o_Cmd_X;
  logic [15:0] o_Cmd_Y;
  logic        o_Frame_Err;
  logic [7:0]  o_Err_Count;

  uart_cmd_framer #(.TIMEOUT_CLKS(T), .SYNC_BYTE(SYNC)) dut (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Rx_DV     (i_Rx_DV),
    .i_Rx_Byte   (i_Rx_Byte),
    .o_Cmd_Valid (o_Cmd_Valid),
    .i_Cmd_Ready (i_Cmd_Ready),
    .o_Cmd_Op    (o_Cmd_Op),
    .o_Cmd_X     (o_Cmd_X),
    .o_Cmd_Y     (o_Cmd_Y),
    .o_Frame_Err (o_Frame_Err),
    .o_Err_Count (o_Err_Count)
  );

  always #5 i_Clock = ~i_Clock;

  int total = 0;
  int bad   = 0;
  int err_seen = 0;

  // Reference model: bytes of the frame in progress, cycle arithmetic for timeout.
  logic [7:0]  fq[$];
  int          cyc = 0;
  int          last_cyc = 0;
  logic        m_valid = 1'b0;
  logic [2:0]  m_op = '0;
  logic [15:0] m_x = '0, m_y = '0;
  logic        m_err = 1'b0;
  logic [7:0]  m_cnt = '0;

  typedef struct packed {logic dv; logic [7:0] b;} ev_t;

  function automatic logic [6:0][7:0] mk_frame(input logic [7:0] op, input logic [15:0] x,
                                               input logic [15:0] y);
    logic [6:0][7:0] f;
    f[0] = SYNC;
    f[1] = op;
    f[2] = x[15:8];
    f[3] = x[7:0];
    f[4] = y[15:8];
    f[5] = y[7:0];
    f[6] = op ^ x[15:8] ^ x[7:0] ^ y[15:8] ^ y[7:0];
    return f;
  endfunction

  task automatic model_edge(input logic dv, input logic [7:0] b, input logic rdy,
                            input logic rst);
    logic       rel;
    logic [7:0] cs;
    cyc++;
    m_err = 1'b0;
    if (rst) begin
      fq.delete();
      m_valid = 1'b0; m_op = '0; m_x = '0; m_y = '0; m_cnt = '0;
      return;
    end
    rel = m_valid && rdy;
    if (!dv) begin
      if (fq.size() > 0 && (cyc - last_cyc) == T) begin
        fq.delete();
        m_err = 1'b1;
      end
      if (rel) m_valid = 1'b0;
    end else begin
      last_cyc = cyc;
      if (fq.size() == 0) begin
        if (b == SYNC) fq.push_back(b);
        if (rel) m_valid = 1'b0;
      end else begin
        fq.push_back(b);
        if (fq.size() == 7) begin
          cs = fq[1] ^ fq[2] ^ fq[3] ^ fq[4] ^ fq[5];
          if (fq[6] == cs && fq[1] >= 8'd1 && fq[1] <= 8'd5 && (!m_valid || rel)) begin
            m_valid = 1'b1;
            m_op    = fq[1][2:0];
            m_x     = {fq[2], fq[3]};
            m_y     = {fq[4], fq[5]};
          end else begin
            m_err = 1'b1;
            if (rel) m_valid = 1'b0;
          end
          fq.delete();
        end else if (rel) begin
          m_valid = 1'b0;
        end
      end
    end
    if (m_err && m_cnt != 8'hFF) m_cnt++;
  endtask

  task automatic step(input logic dv, input logic [7:0] b, input logic rdy, input logic rst);
    @(negedge i_Clock);
    i_Rx_DV = dv; i_Rx_Byte = b; i_Cmd_Ready = rdy; i_Reset = rst;
    @(posedge i_Clock);
    model_edge(dv, b, rdy, rst);
    #1;
    if (o_Frame_Err === 1'b1) err_seen++;
  endtask

  task automatic send(input logic [7:0] b, input logic rdy);
    step(1'b1, b, rdy, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [6:0][7:0] f, input int gap, input logic rdy_cs);
    for (int i = 0; i < 7; i++) begin
      send(f[i], (i == 6) ? rdy_cs : 1'b0);
      if (i < 6 && gap > 0) idle($urandom_range(gap, 0));
    end
  endtask

  task automatic test_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);
    total++; if (o_Cmd_Valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_Cmd_Valid); end
    total++; if ({o_Cmd_Op, o_Cmd_X, o_Cmd_Y} !== 35'd0) begin bad++; $display("FAIL reset_data got=%h %h %h want=0", o_Cmd_Op, o_Cmd_X, o_Cmd_Y); end
    total++; if (o_Frame_Err !== 1'b0 || o_Err_Count !== 8'd0) begin bad++; $display("FAIL reset_err got=%b/%0d want=0/0", o_Frame_Err, o_Err_Count); end
  endtask

  task automatic test_good_frame();
    logic [6:0][7:0] f;
    f = mk_frame(8'h01, 16'd300, 16'd200);
    send_frame(f, 2, 1'b0);
    total++; if (o_Cmd_Valid !== 1'b1) begin bad++; $display("FAIL good_valid got=%b want=1", o_Cmd_Valid); end
    total++; if (o_Cmd_Op !== 3'd1 || o_Cmd_X !== 16'd300 || o_Cmd_Y !== 16'd200) begin bad++; $display("FAIL good_data got=%0d,%0d,%0d want=1,300,200", o_Cmd_Op, o_Cmd_X, o_Cmd_Y); end
    idle(5);
    total++; if (o_Cmd_Valid !== 1'b1 || o_Cmd_X !== 16'd300 || o_Cmd_Y !== 16'd200) begin bad++; $display("FAIL good_hold got=%b,%0d,%0d want=1,300,200", o_Cmd_Valid, o_Cmd_X, o_Cmd_Y); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (o_Cmd_Valid !== 1'b0) begin bad++; $display("FAIL good_release got=%b want=0", o_Cmd_Valid); end
  endtask

  task automatic test_bad_checksum();
    logic [6:0][7:0] f;
    logic [7:0]      op;
    logic [15:0]     x, y;
    f = mk_frame(8'h02, 16'h0010, 16'h0020);
    f[6] = 8'h00;
    send_frame(f, 1, 1'b0);
    total++; if (o_Frame_Err !== 1'b1 || o_Err_Count !== 8'd1) begin bad++; $display("FAIL badcs_err got=%b/%0d want=1/1", o_Frame_Err, o_Err_Count); end
    total++; if (o_Cmd_Valid !== 1'b0) begin bad++; $display("FAIL badcs_valid got=%b want=0", o_Cmd_Valid); end
    idle(1);
    total++; if (o_Frame_Err !== 1'b0) begin bad++; $display("FAIL badcs_pulse got=%b want=0", o_Frame_Err); end
    op = 8'($urandom_range(5, 1)); x = 16'($urandom); y = 16'($urandom);
    send_frame(mk_frame(op, x, y), 3, 1'b0);
    total++; if (o_Cmd_Valid !== 1'b1 || o_Cmd_Op !== op[2:0] || o_Cmd_X !== x || o_Cmd_Y !== y) begin bad++; $display("FAIL badcs_next got=%b,%0d,%h,%h want=1,%0d,%h,%h", o_Cmd_Valid, o_Cmd_Op, o_Cmd_X, o_Cmd_Y, op, x, y); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_bad_opcode();
    logic [7:0]  op;
    logic [15:0] x, y;
    send(8'h00, 1'b0);
    send(8'hFF, 1'b0);
    op = 8'($urandom_range(5, 1)); x = 16'($urandom); y = 16'($urandom);
    send_frame(mk_frame(op, x, y), 0, 1'b0);
    total++; if (o_Cmd_Valid !== 1'b1 || o_Cmd_Op !== op[2:0] || o_Cmd_X !== x || o_Cmd_Y !== y) begin bad++; $display("FAIL noise_frame got=%b,%0d,%h,%h want=1,%0d,%h,%h", o_Cmd_Valid, o_Cmd_Op, o_Cmd_X, o_Cmd_Y, op, x, y); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    send_frame(mk_frame(8'h07, 16'h1234, 16'h5678), 1, 1'b0);
    total++; if (o_Frame_Err !== 1'b1 || o_Err_Count !== 8'd2 || o_Cmd_Valid !== 1'b0) begin bad++; $display("FAIL op07 got=%b/%0d/%b want=1/2/0", o_Frame_Err, o_Err_Count, o_Cmd_Valid); end
    send_frame(mk_frame(8'h81, 16'h0001, 16'h0002), 1, 1'b0);
    total++; if (o_Frame_Err !== 1'b1 || o_Err_Count !== 8'd3 || o_Cmd_Valid !== 1'b0) begin bad++; $display("FAIL op81 got=%b/%0d/%b want=1/3/0", o_Frame_Err, o_Err_Count, o_Cmd_Valid); end
  endtask

  task automatic test_timeout();
    int p0;
    send(SYNC, 1'b0); send(8'h01, 1'b0); send(8'h01, 1'b0);
    p0 = err_seen;
    idle(T - 1);
    total++; if (err_seen != p0 || o_Err_Count !== 8'd3) begin bad++; $display("FAIL tmo_early pulses=%0d count=%0d want=0/3", err_seen - p0, o_Err_Count); end
    idle(1);
    total++; if (o_Frame_Err !== 1'b1 || o_Err_Count !== 8'd4) begin bad++; $display("FAIL tmo_limit got=%b/%0d want=1/4", o_Frame_Err, o_Err_Count); end
    // Back in HUNT: the rest of that frame must be ignored.
    send(8'h2C, 1'b0); send(8'h00, 1'b0); send(8'hC8, 1'b0); send(8'hE4, 1'b0);
    idle(1);
    total++; if (o_Cmd_Valid !== 1'b0 || err_seen != p0 + 1) begin bad++; $display("FAIL tmo_hunt valid=%b pulses=%0d want=0/1", o_Cmd_Valid, err_seen - p0); end
    send(SYNC, 1'b0); send(8'h01, 1'b0); send(8'h01, 1'b0);
    idle(T - 1);
    send(8'h2C, 1'b0);
    total++; if (o_Frame_Err !== 1'b0 || o_Err_Count !== 8'd4) begin bad++; $display("FAIL tmo_edge got=%b/%0d want=0/4", o_Frame_Err, o_Err_Count); end
    send(8'h00, 1'b0); send(8'hC8, 1'b0); send(8'hE4, 1'b0);
    total++; if (o_Cmd_Valid !== 1'b1 || o_Cmd_Op !== 3'd1 || o_Cmd_X !== 16'd300 || o_Cmd_Y !== 16'd200) begin bad++; $display("FAIL tmo_edge_frame got=%b,%0d,%0d,%0d want=1,1,300,200", o_Cmd_Valid, o_Cmd_Op, o_Cmd_X, o_Cmd_Y); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    logic [15:0] xa, ya, xc, yc;
    xa = 16'($urandom); ya = 16'($urandom); xc = 16'($urandom); yc = 16'($urandom);
    send_frame(mk_frame(8'h03, xa, ya), 1, 1'b0);
    send_frame(mk_frame(8'h04, 16'($urandom), 16'($urandom)), 1, 1'b0);
    total++; if (o_Frame_Err !== 1'b1 || o_Err_Count !== 8'd5) begin bad++; $display("FAIL ovr_err got=%b/%0d want=1/5", o_Frame_Err, o_Err_Count); end
    total++; if (o_Cmd_Valid !== 1'b1 || o_Cmd_Op !== 3'd3 || o_Cmd_X !== xa || o_Cmd_Y !== ya) begin bad++; $display("FAIL ovr_keep got=%b,%0d,%h,%h want=1,3,%h,%h", o_Cmd_Valid, o_Cmd_Op, o_Cmd_X, o_Cmd_Y, xa, ya); end
    send_frame(mk_frame(8'h05, xc, yc), 1, 1'b1);
    total++; if (o_Cmd_Valid !== 1'b1 || o_Frame_Err !== 1'b0 || o_Cmd_Op !== 3'd5 || o_Cmd_X !== xc || o_Cmd_Y !== yc) begin bad++; $display("FAIL ovr_swap got=%b,%b,%0d,%h,%h want=1,0,5,%h,%h", o_Cmd_Valid, o_Frame_Err, o_Cmd_Op, o_Cmd_X, o_Cmd_Y, xc, yc); end
    idle(1);
    total++; if (o_Cmd_Valid !== 1'b1 || o_Cmd_X !== xc) begin bad++; $display("FAIL ovr_hold got=%b,%h want=1,%h", o_Cmd_Valid, o_Cmd_X, xc); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [6:0][7:0] f;
    logic [7:0]      op;
    ev_t             evq[$];
    ev_t             e;
    logic            rdy;
    send_frame(mk_frame(8'h02, 16'hA512, 16'h3456), 0, 1'b0);
    total++; if (o_Cmd_Valid !== 1'b1 || o_Cmd_Op !== 3'd2 || o_Cmd_X !== 16'hA512 || o_Cmd_Y !== 16'h3456) begin bad++; $display("FAIL b2b_sync_in_body got=%b,%0d,%h,%h want=1,2,a512,3456", o_Cmd_Valid, o_Cmd_Op, o_Cmd_X, o_Cmd_Y); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int n = 0; n < 30; n++) begin
      op = ($urandom_range(6, 0) == 0) ? 8'($urandom) : 8'($urandom_range(5, 1));
      f = mk_frame(op, 16'($urandom), 16'($urandom));
      if ($urandom_range(3, 0) == 0) f[6] = f[6] ^ 8'h10;
      if ($urandom_range(4, 0) == 0) evq.push_back(ev_t'({1'b1, 8'($urandom)}));
      for (int i = 0; i < 7; i++) begin
        evq.push_back(ev_t'({1'b1, f[i]}));
        repeat (($urandom_range(14, 0) == 0) ? T + 2 : $urandom_range(2, 0))
          evq.push_back(ev_t'({1'b0, 8'h00}));
      end
    end
    foreach (evq[k]) begin
      e = evq[k];
      rdy = ($urandom_range(2, 0) == 0);
      step(e.dv, e.b, rdy, 1'b0);
      total++; if (o_Cmd_Valid !== m_valid) begin bad++; $display("FAIL rnd_valid ev=%0d got=%b want=%b", k, o_Cmd_Valid, m_valid); end
      total++; if (o_Frame_Err !== m_err) begin bad++; $display("FAIL rnd_err ev=%0d got=%b want=%b", k, o_Frame_Err, m_err); end
      total++; if (o_Err_Count !== m_cnt) begin bad++; $display("FAIL rnd_count ev=%0d got=%0d want=%0d", k, o_Err_Count, m_cnt); end
      if (m_valid) begin
        total++; if (o_Cmd_Op !== m_op || o_Cmd_X !== m_x || o_Cmd_Y !== m_y) begin bad++; $display("FAIL rnd_data ev=%0d got=%0d,%h,%h want=%0d,%h,%h", k, o_Cmd_Op, o_Cmd_X, o_Cmd_Y, m_op, m_x, m_y); end
      end
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [7:0]  op;
    logic [15:0] x, y;
    send_frame(mk_frame(8'h01, 16'h0102, 16'h0304), 0, 1'b0);
    send(SYNC, 1'b0); send(8'h02, 1'b0); send(8'h11, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (o_Cmd_Valid !== 1'b0 || {o_Cmd_Op, o_Cmd_X, o_Cmd_Y} !== 35'd0) begin bad++; $display("FAIL rstmid_cmd got=%b,%0d,%h,%h want=0,0,0,0", o_Cmd_Valid, o_Cmd_Op, o_Cmd_X, o_Cmd_Y); end
    total++; if (o_Frame_Err !== 1'b0 || o_Err_Count !== 8'd0) begin bad++; $display("FAIL rstmid_err got=%b/%0d want=0/0", o_Frame_Err, o_Err_Count); end
    op = 8'($urandom_range(5, 1)); x = 16'($urandom); y = 16'($urandom);
    send_frame(mk_frame(op, x, y), 2, 1'b0);
    total++; if (o_Cmd_Valid !== 1'b1 || o_Cmd_Op !== op[2:0] || o_Cmd_X !== x || o_Cmd_Y !== y) begin bad++; $display("FAIL rstmid_next got=%b,%0d,%h,%h want=1,%0d,%h,%h", o_Cmd_Valid, o_Cmd_Op, o_Cmd_X, o_Cmd_Y, op, x, y); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_opcode();
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench exceeded its time limit");
    $fatal(1);
  end

endmodule

// File: doc/uart_cmd_framer.md
# uart_cmd_framer

Command framer that sits directly behind `uart_rx` in the plotter datapath. It consumes the receiver's one-cycle byte strobes and assembles fixed 7-byte command frames, then presents validated plotter commands (opcode, X, Y) to the motion sequencer over a valid/ready handshake. It rejects malformed, stale or overrun traffic and counts those errors.

## Interface
- `TIMEOUT_CLKS`, default 52090: maximum number of idle clocks allowed between bytes inside a frame (10 bit-times at the default baud).
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `i_Clock` input 1: system clock.
- `i_Reset` input 1: synchronous, active-high reset.
- `i_Rx_DV` input 1: byte strobe from `uart_rx`, high for one cycle.
- `i_Rx_Byte` input 8: received byte; valid when `i_Rx_DV` is high.
- `o_Cmd_Valid` output 1: a command is held on the outputs.
- `i_Cmd_Ready` input 1: the sequencer accepts the command.
- `o_Cmd_Op` output 3: opcode. 1 MOVE, 2 DRAW, 3 PEN_UP, 4 PEN_DOWN, 5 HOME.
- `o_Cmd_X` output 16: X coordinate, unsigned.
- `o_Cmd_Y` output 16: Y coordinate, unsigned.
- `o_Frame_Err` output 1: one-cycle pulse on any rejected frame.
- `o_Err_Count` output 8: saturating count of rejected frames.

## Operation
- Frame layout: SYNC, OP, XH, XL, YH, YL, CS.
- Checksum rule: CS = OP^XH^XL^YH^YL (8-bit XOR).
- States:
  - HUNT: discard every byte except SYNC; SYNC goes to BODY with index 0 and checksum accumulator 0.
  - BODY: each strobe stores the byte at the current index (0..4) and XORs it into the accumulator. At index 4 the state moves to CHECK.
  - CHECK: the next strobe is CS. The state then returns to HUNT.
- SYNC received inside BODY or CHECK is ordinary data. There is no resync.
- On the CS byte, the frame is good only if all of these hold:
  - CS equals the accumulator;
  - OP[7:3]==0;
  - OP[2:0] is in 1..5;
  - the output slot is free, or is being freed this cycle (`o_Cmd_Valid & i_Cmd_Ready`).
- Any other outcome at CS: drop the frame, pulse `o_Frame_Err`, and increment `o_Err_Count`. The counter saturates at 255. A held command is never overwritten.
- Timeout:
  - An idle counter runs only in BODY and CHECK.
  - It clears on every `i_Rx_DV`.
  - When it reaches TIMEOUT_CLKS-1 with no strobe, the state goes to HUNT, `o_Frame_Err` pulses and the error count increments.
  - If a strobe arrives on the timeout cycle, the strobe wins and no error is raised.
- Output slot:
  - The slot is a single register.
  - `o_Cmd_Valid` falls the cycle after a handshake (`o_Cmd_Valid & i_Cmd_Ready`), unless a good frame completes in that same cycle. In that case the new command loads and valid stays high.
  - `o_Cmd_Op`, `o_Cmd_X` and `o_Cmd_Y` are stable while valid is high.
- Reset state:
  - HUNT, index 0, accumulator 0, idle counter 0.
  - `o_Cmd_Valid`=0, `o_Cmd_Op`=0, `o_Cmd_X`=0, `o_Cmd_Y`=0.
  - `o_Frame_Err`=0, `o_Err_Count`=0.
  - Reset mid-frame discards the partial frame and any held command.
- `i_Cmd_Ready` is ignored while `o_Cmd_Valid` is low.

## Timing
- Latency: a CS strobe at cycle N gives `o_Cmd_Valid`=1 with data at cycle N+1. On a rejected frame, `o_Frame_Err` is high at cycle N+1 only.
- A timeout error is visible on the cycle after the idle counter hits its limit.
- Strobes may arrive back-to-back (every cycle). The block must accept them with no loss.
- The error count updates in the same cycle as the `o_Frame_Err` pulse.
- There are no combinational paths from inputs to outputs.

## Test plan
- Good frame: A5 01 01 2C 00 C8 E4 with ready held low. Expect `o_Cmd_Valid`=1 one cycle after the E4 strobe, with Op=1, X=300, Y=200, held until ready. Valid falls the cycle after ready.
- Bad checksum: A5 02 00 10 00 20 00. Expect one `o_Frame_Err` pulse, `o_Err_Count`=1, valid stays 0. A following good frame is then accepted.
- Bad opcode and noise:
  - Leading bytes 00 FF before the good frame are ignored.
  - A frame with OP=07 and a correct CS is rejected with an error pulse.
  - A frame with OP=81 and a correct CS is also rejected.
- Timeout: A5 01 01 followed by silence for TIMEOUT_CLKS cycles (use TIMEOUT_CLKS=20). Expect an error at the limit and HUNT. Then repeat with a byte arriving exactly on the limit cycle and expect no error.
- Overrun and simultaneous release:
  - Hold the first command unacked and send a second good frame: expect an error and the first command unchanged.
  - Repeat with ready asserted on the second frame's CS cycle: the second command loads and valid stays continuously high.
- Back-to-back strobes, SYNC inside the body, and reset:
  - A frame sent with `i_Rx_DV` high on 7 consecutive cycles, containing XH=A5, decodes correctly.
  - Asserting `i_Reset` after 3 bytes leaves all outputs 0, and the next full frame decodes.
